// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite blitter: pixel/address typedefs,
// the latched blit descriptor and the blitter FSM state encoding.
package sprite_pkg;

  typedef logic [3:0]  color_idx_t;
  typedef logic [17:0] rom_addr_t;
  typedef logic [16:0] fb_addr_t;

  typedef struct packed {
    rom_addr_t  base;
    logic [9:0] w;
    logic [9:0] h;
    logic [9:0] x;
    logic [9:0] y;
  } blit_desc_t;

  localparam int unsigned FB_W_DEF       = 320;
  localparam int unsigned FB_H_DEF       = 240;
  localparam color_idx_t  TRANSP_IDX_DEF = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } blit_state_t;

endpackage

// File: rtl/sprite_blitter_if.sv
// Memory-side bus of the blitter: sprite ROM read port and framebuffer write port.
interface sprite_blitter_if;
  import sprite_pkg::*;

  rom_addr_t  rom_addr;
  color_idx_t rom_data;
  logic       fb_we;
  fb_addr_t   fb_addr;
  color_idx_t fb_data;
  logic       fb_ready;

  modport master (
    output rom_addr, fb_we, fb_addr, fb_data,
    input  rom_data, fb_ready
  );

  modport slave (
    input  rom_addr, fb_we, fb_addr, fb_data,
    output rom_data, fb_ready
  );
endinterface

// File: rtl/sprite_blitter_addr_gen.sv
// Stage-0 address generator: row/col counters, source and framebuffer
// accumulators, clip flag and last-pixel flag for the current pixel.
module blit_addr_gen
  import sprite_pkg::*;
#(
  parameter int unsigned FB_W = FB_W_DEF,
  parameter int unsigned FB_H = FB_H_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  input  blit_desc_t desc,
  input  logic       hflip,
  output rom_addr_t  src_addr,
  output fb_addr_t   fb_addr,
  output logic       clip,
  output logic       last
);

  localparam logic [10:0] FB_W11 = 11'(FB_W);
  localparam logic [10:0] FB_H11 = 11'(FB_H);
  localparam logic [19:0] FB_W20 = 20'(FB_W);

  logic [9:0]  col, row, w_q, w_m1, h_m1;
  logic [10:0] x0, x_cur, y_cur;
  logic [19:0] row_fb;
  rom_addr_t   row_start, src_ptr, next_row_start;
  logic        hflip_q, row_end;

  assign row_end        = (col == w_m1);
  assign next_row_start = row_start + rom_addr_t'(w_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      w_q       <= '0;
      w_m1      <= '0;
      h_m1      <= '0;
      x0        <= '0;
      x_cur     <= '0;
      y_cur     <= '0;
      row_fb    <= '0;
      row_start <= '0;
      src_ptr   <= '0;
      hflip_q   <= 1'b0;
    end else if (load) begin
      col       <= '0;
      row       <= '0;
      w_q       <= desc.w;
      w_m1      <= desc.w - 10'd1;
      h_m1      <= desc.h - 10'd1;
      x0        <= {1'b0, desc.x};
      x_cur     <= {1'b0, desc.x};
      y_cur     <= {1'b0, desc.y};
      // Constant-coefficient product, evaluated once per blit.
      row_fb    <= 20'(desc.y) * FB_W20 + 20'(desc.x);
      row_start <= desc.base;
      src_ptr   <= hflip ? desc.base + rom_addr_t'(desc.w - 10'd1) : desc.base;
      hflip_q   <= hflip;
    end else if (step) begin
      if (row_end) begin
        col       <= '0;
        row       <= row + 10'd1;
        x_cur     <= x0;
        y_cur     <= y_cur + 11'd1;
        row_fb    <= row_fb + FB_W20;
        row_start <= next_row_start;
        src_ptr   <= hflip_q ? next_row_start + rom_addr_t'(w_m1) : next_row_start;
      end else begin
        col     <= col + 10'd1;
        x_cur   <= x_cur + 11'd1;
        src_ptr <= hflip_q ? src_ptr - rom_addr_t'(1) : src_ptr + rom_addr_t'(1);
      end
    end
  end

  assign src_addr = src_ptr;
  assign fb_addr  = fb_addr_t'(row_fb + 20'(col));
  assign clip     = (x_cur >= FB_W11) || (y_cur >= FB_H11);
  assign last     = row_end && (row == h_m1);

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: copies a WxH palette-index sprite from ROM into the framebuffer
// through a 2-stage pipeline. Optional feature macro: SPRITE_HFLIP_EN (adds hflip).
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int unsigned FB_W       = FB_W_DEF,
  parameter int unsigned FB_H       = FB_H_DEF,
  parameter color_idx_t  TRANSP_IDX = TRANSP_IDX_DEF
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       start,
  input  rom_addr_t  spr_base,
  input  logic [9:0] spr_w,
  input  logic [9:0] spr_h,
  input  logic [9:0] dst_x,
  input  logic [9:0] dst_y,
`ifdef SPRITE_HFLIP_EN
  input  logic       hflip,
`endif
  output logic       busy,
  output logic       done,
  sprite_blitter_if.master mem
);

  blit_state_t state, state_next;
  blit_desc_t  desc;
  logic        load, step, stall, we_int, hflip_in;
  rom_addr_t   src_addr, s1_rom_addr;
  fb_addr_t    gen_fb_addr, s1_fb_addr;
  logic        gen_clip, gen_last, s1_valid, s1_clip;

`ifdef SPRITE_HFLIP_EN
  assign hflip_in = hflip;
`else
  assign hflip_in = 1'b0;
`endif

  assign desc = '{base: spr_base, w: spr_w, h: spr_h, x: dst_x, y: dst_y};

  blit_addr_gen #(.FB_W(FB_W), .FB_H(FB_H)) u_addr_gen (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .load     (load),
    .step     (step),
    .desc     (desc),
    .hflip    (hflip_in),
    .src_addr (src_addr),
    .fb_addr  (gen_fb_addr),
    .clip     (gen_clip),
    .last     (gen_last)
  );

  assign we_int = s1_valid && !s1_clip && (mem.rom_data != TRANSP_IDX);
  assign stall  = we_int && !mem.fb_ready;

  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state)
      ST_IDLE: if (start) begin
        load       = 1'b1;
        state_next = (spr_w == '0 || spr_h == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: if (!stall) begin
        step = 1'b1;
        if (gen_last) state_next = ST_DRAIN;
      end
      ST_DRAIN: if (!stall) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid    <= 1'b0;
      s1_clip     <= 1'b0;
      s1_fb_addr  <= '0;
      s1_rom_addr <= '0;
    end else if (!stall) begin
      s1_valid    <= (state == ST_RUN);
      s1_clip     <= gen_clip;
      s1_fb_addr  <= gen_fb_addr;
      s1_rom_addr <= src_addr;
    end
  end

  // The ROM read is registered, so during a stall the ROM must be re-addressed
  // with stage 1's pixel to keep rom_data (and thus fb_data) stable.
  assign mem.rom_addr = stall ? s1_rom_addr : src_addr;
  assign mem.fb_we    = we_int;
  assign mem.fb_addr  = s1_fb_addr;
  assign mem.fb_data  = s1_valid ? mem.rom_data : '0;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule
